// File: rtl/posit_mac_pkg.sv
// Shared sizing defaults and constants for the posit MAC accumulation stage.
package posit_mac_pkg;

    localparam int N_DEF  = 5;
    localparam int SW_DEF = 6;
    localparam int QW_DEF = 32;
    localparam int QF_DEF = 16;

    // Quire pattern presented for a NaR dot product: sign bit only.
    localparam logic [QW_DEF-1:0] NAR_QUIRE = {1'b1, {(QW_DEF-1){1'b0}}};

    typedef struct packed {
        logic nar;
        logic ovf;
    } beat_flags_t;

endpackage

// File: rtl/posit_quire_align.sv
// Stage-1 datapath: shifts a 2N-bit fraction product into a saturated,
// signed fixed-point quire term.
module posit_quire_align
    import posit_mac_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int SW = SW_DEF,
    parameter int QW = QW_DEF,
    parameter int QF = QF_DEF
) (
    input  logic [2*N-1:0] i_prod,
    input  logic           i_sign,
    input  logic [SW-1:0]  i_scale,
    input  logic           i_zero,
    input  logic           i_nar,
    output logic [QW-1:0]  o_term,
    output beat_flags_t    o_flags
);

    localparam int PW = 2 * N;
    localparam int WW = PW + QW;
    localparam int HW = SW + 2;
    localparam logic [HW-1:0] SH_OFF_V = HW'(QF - 2 * (N - 1));
    localparam logic [HW-1:0] QW_V     = HW'(QW);
    localparam logic [HW-1:0] PW_V     = HW'(PW);

    logic [HW-1:0] w_sh;
    logic [HW-1:0] w_rsh;
    logic [WW-1:0] w_lwide;
    logic [PW-1:0] w_rmag;
    logic [QW-1:0] w_mag;
    logic          w_sat;

    // Two guard bits keep scale + offset from wrapping before the sign test.
    assign w_sh    = {{2{i_scale[SW-1]}}, i_scale} + SH_OFF_V;
    assign w_rsh   = -w_sh;
    assign w_lwide = {{QW{1'b0}}, i_prod} << w_sh;
    assign w_rmag  = i_prod >> w_rsh;

    always_comb begin
        w_mag = '0;
        w_sat = 1'b0;
        if (w_sh[HW-1]) begin
            if (w_rsh < PW_V) begin
                w_mag = {{(QW-PW){1'b0}}, w_rmag};
            end
        end else if (w_sh >= QW_V) begin
            w_sat = |i_prod;
        end else begin
            w_sat = |w_lwide[WW-1:QW-1];
            w_mag = {1'b0, w_lwide[QW-2:0]};
        end
        if (w_sat) begin
            w_mag = {1'b0, {(QW-1){1'b1}}};
        end
    end

    always_comb begin
        o_term  = '0;
        o_flags = '0;
        if (i_nar) begin
            o_flags.nar = 1'b1;
        end else if (!i_zero) begin
            o_term      = i_sign ? -w_mag : w_mag;
            o_flags.ovf = w_sat;
        end
    end

endmodule

// File: rtl/posit_mac_accumulator.sv
// Two-stage posit MAC accumulator: aligns each product into a quire term,
// then sums a stream of terms into a saturating quire until the last beat.
module posit_mac_accumulator
    import posit_mac_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int SW = SW_DEF,
    parameter int QW = QW_DEF,
    parameter int QF = QF_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_in_valid,
    output logic           o_in_ready,
    input  logic [2*N-1:0] i_in_prod,
    input  logic           i_in_sign,
    input  logic [SW-1:0]  i_in_scale,
    input  logic           i_in_zero,
    input  logic           i_in_nar,
    input  logic           i_in_last,
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [QW-1:0]  o_out_acc,
    output logic           o_out_nar,
    output logic           o_out_ovf
);

    localparam logic [QW-1:0] NAR_Q = (QW == QW_DEF) ? QW'(NAR_QUIRE)
                                                     : {1'b1, {(QW-1){1'b0}}};

    logic          w_adv;
    logic [QW-1:0] w_term;
    beat_flags_t   w_flags;
    logic [QW:0]   w_sum_ext;
    logic [QW-1:0] w_sum;
    logic          w_sum_ovf;
    beat_flags_t   w_total;

    logic          r_s1_valid;
    logic          r_s1_last;
    logic [QW-1:0] r_s1_term;
    beat_flags_t   r_s1_flags;
    logic [QW-1:0] r_acc;
    beat_flags_t   r_sticky;
    logic          r_out_valid;
    logic [QW-1:0] r_out_acc;
    logic          r_out_nar;
    logic          r_out_ovf;

    // A pending, unaccepted result freezes the whole pipeline.
    assign w_adv      = !r_out_valid || i_out_ready;
    assign o_in_ready = w_adv;

    posit_quire_align #(
        .N  (N),
        .SW (SW),
        .QW (QW),
        .QF (QF)
    ) u_align (
        .i_prod  (i_in_prod),
        .i_sign  (i_in_sign),
        .i_scale (i_in_scale),
        .i_zero  (i_in_zero),
        .i_nar   (i_in_nar),
        .o_term  (w_term),
        .o_flags (w_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_term  <= '0;
            r_s1_flags <= '0;
        end else if (w_adv) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_last  <= i_in_last;
                r_s1_term  <= w_term;
                r_s1_flags <= w_flags;
            end
        end
    end

    // Sign-extended add; a carry disagreeing with the sign bit means overflow.
    assign w_sum_ext = {r_acc[QW-1], r_acc} + {r_s1_term[QW-1], r_s1_term};
    assign w_sum_ovf = w_sum_ext[QW] ^ w_sum_ext[QW-1];
    assign w_sum     = w_sum_ovf ? {w_sum_ext[QW], {(QW-1){~w_sum_ext[QW]}}}
                                 : w_sum_ext[QW-1:0];
    assign w_total   = '{nar: r_sticky.nar | r_s1_flags.nar,
                         ovf: r_sticky.ovf | r_s1_flags.ovf | w_sum_ovf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_sticky    <= '0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_nar   <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                if (r_s1_last) begin
                    r_out_acc <= w_total.nar ? NAR_Q : w_sum;
                    r_out_nar <= w_total.nar;
                    r_out_ovf <= w_total.ovf;
                    r_acc     <= '0;
                    r_sticky  <= '0;
                end else begin
                    r_acc    <= w_sum;
                    r_sticky <= w_total;
                end
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_acc   = r_out_acc;
    assign o_out_nar   = r_out_nar;
    assign o_out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_posit_mac_accumulator.sv
// Bench for posit_mac_accumulator: constant vector table, hand-written
// handshake/reset sequences, and random beats against a real-valued model.
module tb_posit_mac_accumulator;
    import posit_mac_pkg::*;

    localparam int N = N_DEF;
    localparam int SW = SW_DEF;
    localparam int QW = QW_DEF;
    localparam int QF = QF_DEF;
    localparam longint QMAX = 64'sd2147483647;
    localparam longint QMIN = -QMAX - 1;

    typedef struct {
        logic [2*N-1:0]  prod;
        logic            sign;
        logic [SW-1:0]   scale;
        logic            zero;
        logic            nar;
        logic            last;
        logic [QW-1:0]   expAcc;
        logic            expNar;
        logic            expOvf;
    } vec_t;

    typedef struct {
        logic [QW-1:0] acc;
        logic          nar;
        logic          ovf;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inValid;
    logic          inReady;
    logic [2*N-1:0] inProd;
    logic          inSign;
    logic [SW-1:0] inScale;
    logic          inZero;
    logic          inNar;
    logic          inLast;
    logic          outValid;
    logic          outReady;
    logic [QW-1:0] outAcc;
    logic          outNar;
    logic          outOvf;

    int     testsRun = 0;
    int     testsFailed = 0;
    int     resultIdx = 0;
    bit     modelOn = 1'b0;
    bit     randReady = 1'b0;
    res_t   expQ[$];
    vec_t   vecs[$];
    longint mAcc = 0;
    bit     mNar = 1'b0;
    bit     mOvf = 1'b0;

    always #5 clk = ~clk;

    posit_mac_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_in_prod   (inProd),
        .i_in_sign   (inSign),
        .i_in_scale  (inScale),
        .i_in_zero   (inZero),
        .i_in_nar    (inNar),
        .i_in_last   (inLast),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_out_acc   (outAcc),
        .o_out_nar   (outNar),
        .o_out_ovf   (outOvf)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input int prod, input int sign, input int scale,
                                input int zero, input int nar, input int last,
                                input logic [31:0] expAcc, input int expNar,
                                input int expOvf);
        vec_t v;
        v.prod   = (2*N)'(prod);
        v.sign   = (sign != 0);
        v.scale  = SW'(scale);
        v.zero   = (zero != 0);
        v.nar    = (nar != 0);
        v.last   = (last != 0);
        v.expAcc = expAcc;
        v.expNar = (expNar != 0);
        v.expOvf = (expOvf != 0);
        return v;
    endfunction

    function automatic void pushExpect(input logic [31:0] acc, input bit nar, input bit ovf);
        res_t r;
        r.acc = acc;
        r.nar = nar;
        r.ovf = ovf;
        expQ.push_back(r);
    endfunction

    // Reference: value = prod * 2^(scale - 2(N-1)), quire LSB = 2^-QF, plain arithmetic.
    function automatic void modelAccept(input vec_t v);
        real    mag;
        longint term;
        longint sum;
        bit     beatOvf;
        int     e;
        term = 0;
        beatOvf = 1'b0;
        if (!v.nar && !v.zero) begin
            mag = real'(v.prod);
            e = int'($signed(v.scale)) + QF - 2 * (N - 1);
            for (int k = 0; k < e; k++) mag = mag * 2.0;
            for (int k = 0; k < -e; k++) mag = mag / 2.0;
            if (mag >= 2147483648.0) begin
                term = QMAX;
                beatOvf = 1'b1;
            end else begin
                term = longint'($rtoi(mag));
            end
            if (v.sign) term = -term;
        end
        sum = mAcc + term;
        if (sum > QMAX) begin
            sum = QMAX;
            beatOvf = 1'b1;
        end else if (sum < QMIN) begin
            sum = QMIN;
            beatOvf = 1'b1;
        end
        mNar = mNar | v.nar;
        mOvf = mOvf | beatOvf;
        if (v.last) begin
            pushExpect(mNar ? 32'h8000_0000 : 32'(sum), mNar, mOvf);
            mAcc = 0;
            mNar = 1'b0;
            mOvf = 1'b0;
        end else begin
            mAcc = sum;
        end
    endfunction

    // Handshakes are observed mid-cycle; they complete on the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (modelOn && inValid && inReady) begin
                vec_t v;
                v = mk(int'(inProd), int'(inSign), int'($signed(inScale)), int'(inZero),
                       int'(inNar), int'(inLast), '0, 0, 0);
                modelAccept(v);
            end
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected result", outAcc, 32'hxxxx_xxxx);
                end else begin
                    res_t e;
                    e = expQ.pop_front();
                    checkOutput($sformatf("result %0d acc", resultIdx), outAcc, e.acc);
                    checkOutput($sformatf("result %0d nar", resultIdx), 32'(outNar), 32'(e.nar));
                    checkOutput($sformatf("result %0d ovf", resultIdx), 32'(outOvf), 32'(e.ovf));
                end
                resultIdx++;
            end
        end
    end

    task automatic setBeat(input vec_t v);
        inProd  = v.prod;
        inSign  = v.sign;
        inScale = v.scale;
        inZero  = v.zero;
        inNar   = v.nar;
        inLast  = v.last;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input vec_t v);
        int waitCycles;
        bit done;
        waitCycles = 0;
        done = 1'b0;
        setBeat(v);
        inValid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (inReady) begin
                done = 1'b1;
            end else if (++waitCycles > 200) begin
                checkOutput("beat accept timeout", 32'(inReady), 32'd1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
    endtask

    task automatic waitDrain();
        int cycles;
        cycles = 0;
        while (expQ.size() != 0 && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("drain pending results", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        int   sc;
        rst_n = 1'b1;
        inValid = 1'b0;
        outReady = 1'b1;
        setBeat(mk(0, 0, 0, 0, 0, 0, '0, 0, 0));
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 32'(outValid), 32'd0);
        checkOutput("reset out_acc", outAcc, 32'd0);
        checkOutput("reset out_nar", 32'(outNar), 32'd0);
        checkOutput("reset out_ovf", 32'(outOvf), 32'd0);
        checkOutput("reset in_ready", 32'(inReady), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vecs.push_back(mk(12'h100, 0, 0, 0, 0, 0, '0, 0, 0));
        vecs.push_back(mk(12'h180, 0, 1, 0, 0, 1, 32'h0004_0000, 0, 0));
        vecs.push_back(mk(12'h100, 0, 0, 0, 0, 0, '0, 0, 0));
        vecs.push_back(mk(12'h100, 1, 0, 0, 0, 1, 32'h0000_0000, 0, 0));
        vecs.push_back(mk(12'h100, 1, 0, 0, 0, 1, 32'hFFFF_0000, 0, 0));
        vecs.push_back(mk(12'h100, 0, 20, 0, 0, 1, 32'h7FFF_FFFF, 0, 1));
        vecs.push_back(mk(12'h100, 0, -17, 0, 0, 1, 32'h0000_0000, 0, 0));
        vecs.push_back(mk(12'h100, 0, 0, 0, 0, 0, '0, 0, 0));
        vecs.push_back(mk(12'h100, 0, 0, 0, 1, 0, '0, 0, 0));
        vecs.push_back(mk(12'h100, 0, 0, 0, 0, 1, 32'h8000_0000, 1, 0));
        vecs.push_back(mk(12'h100, 0, 0, 0, 0, 1, 32'h0001_0000, 0, 0));
        vecs.push_back(mk(12'h3FF, 0, 20, 1, 0, 0, '0, 0, 0));
        vecs.push_back(mk(12'h100, 0, 0, 0, 0, 1, 32'h0001_0000, 0, 0));
        vecs.push_back(mk(12'h100, 0, 14, 0, 0, 0, '0, 0, 0));
        vecs.push_back(mk(12'h100, 0, 14, 0, 0, 1, 32'h7FFF_FFFF, 0, 1));
        vecs.push_back(mk(12'h100, 1, 14, 0, 0, 0, '0, 0, 0));
        vecs.push_back(mk(12'h100, 1, 14, 0, 0, 0, '0, 0, 0));
        vecs.push_back(mk(12'h100, 1, 14, 0, 0, 1, 32'h8000_0000, 0, 1));
        vecs.push_back(mk(12'h100, 0, -16, 0, 0, 1, 32'h0000_0001, 0, 0));
        vecs.push_back(mk(12'h3FF, 0, -15, 0, 0, 1, 32'h0000_0007, 0, 0));
        vecs.push_back(mk(12'h180, 1, -16, 0, 0, 1, 32'hFFFF_FFFF, 0, 0));
        vecs.push_back(mk(12'h3FF, 0, -20, 0, 0, 1, 32'h0000_0000, 0, 0));
        vecs.push_back(mk(12'h1FF, 0, 14, 0, 0, 1, 32'h7FC0_0000, 0, 0));
        vecs.push_back(mk(12'h100, 0, 15, 0, 0, 1, 32'h7FFF_FFFF, 0, 1));
        foreach (vecs[i]) begin
            if (vecs[i].last) pushExpect(vecs[i].expAcc, vecs[i].expNar, vecs[i].expOvf);
            applyStimulus(vecs[i]);
        end
        waitDrain();

        // Latency and backpressure: result held while the consumer stalls.
        outReady = 1'b0;
        pushExpect(32'h0004_0000, 1'b0, 1'b0);
        pushExpect(32'h0001_0000, 1'b0, 1'b0);
        applyStimulus(mk(12'h100, 0, 0, 0, 0, 0, '0, 0, 0));
        applyStimulus(mk(12'h180, 0, 1, 0, 0, 1, '0, 0, 0));
        @(negedge clk);
        checkOutput("latency cycle 2 out_valid", 32'(outValid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("latency cycle 3 out_valid", 32'(outValid), 32'd1);
        checkOutput("latency cycle 3 out_acc", outAcc, 32'h0004_0000);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                setBeat(mk(12'h100, 0, 0, 0, 0, 1, '0, 0, 0));
                inValid = 1'b1;
            end
            @(negedge clk);
            checkOutput($sformatf("stall %0d in_ready", k), 32'(inReady), 32'd0);
            checkOutput($sformatf("stall %0d out_acc", k), outAcc, 32'h0004_0000);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("queued beat accepted", 32'(inReady), 32'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        waitDrain();

        // Mid-stream reset discards partial sum and in-flight beat.
        applyStimulus(mk(12'h100, 0, 0, 0, 0, 0, '0, 0, 0));
        applyStimulus(mk(12'h100, 0, 0, 0, 0, 0, '0, 0, 0));
        rst_n = 1'b0;
        #2;
        checkOutput("mid reset out_valid", 32'(outValid), 32'd0);
        checkOutput("mid reset out_acc", outAcc, 32'd0);
        checkOutput("mid reset out_nar", 32'(outNar), 32'd0);
        checkOutput("mid reset out_ovf", 32'(outOvf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pushExpect(32'h0001_0000, 1'b0, 1'b0);
        applyStimulus(mk(12'h100, 0, 0, 0, 0, 1, '0, 0, 0));
        waitDrain();

        // Random beats with random consumer backpressure.
        modelOn = 1'b1;
        randReady = 1'b1;
        fork
            while (randReady) begin
                @(posedge clk);
                #1;
                if (randReady) outReady = ($urandom % 10) < 7;
            end
        join_none
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 8 == 0) sc = int'($urandom_range(63, 0)) - 32;
            else sc = int'($urandom_range(20, 0)) - 10;
            v = mk(int'($urandom_range(1023, 256)), int'($urandom % 2), sc,
                   int'($urandom % 16 == 0), int'($urandom % 40 == 0),
                   int'(($urandom % 4 == 0) || (i == 399)), '0, 0, 0);
            if ($urandom % 5 == 0) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(v);
        end
        randReady = 1'b0;
        @(posedge clk);
        #2;
        outReady = 1'b1;
        waitDrain();
        modelOn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/posit_mac_accumulator.md
# posit_mac_accumulator

Accumulation stage of the posit MAC datapath, directly downstream of the fraction multiplier. It takes the 2N-bit unsigned fraction product plus the sign and scale produced by the decode/multiply stages. It aligns each product into a signed fixed-point quire and accumulates a stream of products until `in_last`, then presents the saturated sum to the encode stage. The pipeline has two stages with valid/ready handshakes on both sides.

## Interface
- `N`, 5: fraction width including hidden bit; product width is 2N with 2(N-1) fraction bits.
- `SW`, 6: width of signed scale input.
- `QW`, 32: quire width, two's complement.
- `QF`, 16: quire fraction bits.

Ports:
- `clk` in 1: clock; single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: product beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_prod` in 2N: unsigned product magnitude, value in [1,4) when nonzero.
- `in_sign` in 1: product sign (1 = negative).
- `in_scale` in SW: signed combined exponent of the product.
- `in_zero` in 1: product is zero; `in_prod`, `in_sign` and `in_scale` are ignored.
- `in_nar` in 1: product is NaR.
- `in_last` in 1: final beat of the current dot product.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_acc` out QW: accumulated quire.
- `out_nar` out 1: at least one NaR beat was seen in the dot product.
- `out_ovf` out 1: saturation occurred during alignment or accumulation.

## Operation
- Advance enable: `adv = !out_valid || out_ready`. `in_ready = adv`. When `adv` is low, all stages hold.
- **Stage 1, align.** On an accepted beat, compute the shift `sh = in_scale + QF - 2(N-1)`.
  - If `sh >= 0`, the magnitude is shifted left by `sh`.
  - If `sh < 0`, the magnitude is shifted right and truncated. Shifts of 2N or more give 0.
  - If the magnitude is 2^(QW-1) or greater, it saturates to 2^(QW-1)-1 and the per-beat overflow flag is set.
  - The term is negated when `in_sign` is 1.
  - `in_zero` gives a term of 0. `in_nar` gives a term of 0 and sets the per-beat NaR flag.
  - Stage 1 registers: `s1_valid`, `s1_term`, `s1_last`, `s1_nar`, `s1_ovf`.
- **Stage 2, accumulate.** When `adv` is high and `s1_valid` is high:
  - `sum = acc + s1_term`, with signed saturation to [-2^(QW-1), 2^(QW-1)-1]. Saturation sets overflow.
  - Sticky `nar_st` and `ovf_st` flags are ORed with the stage-1 flags.
  - If `s1_last` is 0: `acc <= sum`.
  - If `s1_last` is 1: `out_acc <= sum`, `out_nar <= nar`, `out_ovf <= ovf` (both including the current beat), `out_valid <= 1`. Then `acc`, `nar_st` and `ovf_st` are cleared to 0.
- If NaR is flagged, `out_acc` is forced to 0x8000_0000 (sign bit only).
- `out_valid` clears on `out_ready` unless a new last beat is completing in the same cycle. In that case the new result replaces the old one and `out_valid` stays 1.
- Reset: all valids, `acc`, sticky flags, `out_acc`, `out_nar` and `out_ovf` are 0.
- Reset asserted mid-stream discards the partial sum and any in-flight beat.

## Timing
- Latency: a last beat accepted in cycle 0 produces `out_valid` in cycle 2.
- Throughput is one beat per cycle while `out_ready` is high or no result is pending.
- A one-beat dot product (`in_valid` and `in_last` together) is legal.
- Back-to-back dot products need no bubble.
- While `out_valid` is high and `out_ready` is low, `in_ready` is 0 and `out_acc` is stable.

## Structure
- `posit_mac_pkg` holds the defaults for `N`, `QW`, `QF` and `SW`, plus the NaR quire constant.
- Sub-module `posit_quire_align` contains the combinational shift, saturation and negate of stage 1. It is instantiated once.

## Test plan
- Beats (`prod`=0x100, scale 0, last=0) then (`prod`=0x180, scale 1, last=1) -> `out_acc`=0x0004_0000 in cycle 3 relative to the first beat; `out_nar`=0, `out_ovf`=0.
- Beats +1.0 then −1.0 (sign=1, same `prod`=0x100, scale 0), last -> `out_acc`=0; then −1.0 alone -> 0xFFFF_0000.
- `prod`=0x100, scale 20, last -> `out_acc`=0x7FFF_FFFF, `out_ovf`=1. Scale −17 -> `out_acc`=0.
- Three beats with the middle one NaR -> `out_acc`=0x8000_0000, `out_nar`=1. The next dot product (+1.0, last) -> 0x0001_0000, `out_nar`=0.
- `out_ready` held low for 4 cycles with a result pending -> `in_ready`=0 and `out_acc` stable. Release -> the queued beat is accepted on the next cycle and no beat is lost.
- `rst_n` pulsed low after two non-last beats -> outputs go to 0 immediately. The next last beat of +1.0 yields 0x0001_0000.
